// File: rtl/bypass_fifo.sv
// Circular FIFO with bypass: within a cycle enqueue is ordered before dequeue,
// so an empty FIFO forwards enq_data straight to deq_data with zero latency.
module bypass_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [W-1:0]  enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [W-1:0]  deq_data,
  input  logic          clear,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;
  logic bypass;
  logic do_write;
  logic do_read;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // enq_ready depends only on stored state, never on the dequeue side.
  assign enq_ready = ~full;
  assign deq_valid = ~empty | enq_valid;
  assign deq_data  = empty ? enq_data : mem[head];
  assign count     = count_q;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  // A same-cycle enq/deq on an empty queue passes the item through unstored.
  assign bypass   = empty & enq_fire & deq_fire;
  assign do_write = enq_fire & ~bypass;
  assign do_read  = deq_fire & ~bypass;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[tail] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_write) begin
        tail <= tail + PW'(1);
      end
      if (do_read) begin
        head <= head + PW'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_fifo.sv
// Self-checking bench for bypass_fifo: constant vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bypass_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic          enq_ready;
  logic [W-1:0]  enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic [W-1:0]  deq_data;
  logic          clear;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q [$];

  typedef struct {
    logic          rs;
    logic          cl;
    logic          ev;
    logic [W-1:0]  ed;
    logic          dr;
    logic          er;
    logic          dv;
    logic [W-1:0]  dd;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [14];

  bypass_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .clear     (clear),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Drive inputs (called just after a falling edge), then settle.
  task automatic applyStimulus(input logic ev, input logic [W-1:0] ed,
                               input logic dr, input logic cl, input logic rs);
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    clear     = cl;
    rst       = rs;
    #1;
  endtask

  task automatic checkValue(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic er, input logic dv,
                             input logic [W-1:0] dd, input logic [CW-1:0] cnt);
    checkValue({name, ".enq_ready"}, W'(enq_ready), W'(er));
    checkValue({name, ".deq_valid"}, W'(deq_valid), W'(dv));
    checkValue({name, ".deq_data"},  deq_data, dd);
    checkValue({name, ".count"},     W'(count), W'(cnt));
  endtask

  // Reference outputs derived from the queue occupancy and current inputs.
  task automatic modelCheck(input string name);
    logic          er;
    logic          dv;
    logic [W-1:0]  dd;
    int            n;
    n  = model_q.size();
    er = (n != DEPTH);
    dv = (n != 0) || enq_valid;
    dd = (n != 0) ? model_q[0] : enq_data;
    checkOutput(name, er, dv, dd, CW'(n));
  endtask

  // Advance one clock: model applies enq, then deq, then clear/reset.
  task automatic clockEdge();
    int   n;
    logic ef;
    logic df;
    n  = model_q.size();
    ef = enq_valid && (n != DEPTH);
    df = ((n != 0) || enq_valid) && deq_ready;
    @(posedge clk);
    if (rst || clear) begin
      model_q.delete();
    end else begin
      if (ef) model_q.push_back(enq_data);
      if (df) void'(model_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic cycle(input string name, input logic ev, input logic [W-1:0] ed,
                       input logic dr, input logic cl, input logic rs);
    applyStimulus(ev, ed, dr, cl, rs);
    modelCheck(name);
    clockEdge();
  endtask

  initial begin
    //             rs    cl    ev    ed            dr    er    dv    dd            cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd1,        1'b0, 1'b1, 1'b1, 32'd1,        3'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'd2,        1'b0, 1'b1, 1'b1, 32'd1,        3'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'd3,        1'b0, 1'b1, 1'b1, 32'd1,        3'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd4,        1'b0, 1'b1, 1'b1, 32'd1,        3'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'd5,        1'b0, 1'b0, 1'b1, 32'd1,        3'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'd1,        3'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd2,        3'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd3,        3'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'd4,        3'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        3'd0};

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clockEdge();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].ev, vecs[i].ed, vecs[i].dr, vecs[i].cl, vecs[i].rs);
      checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].dv, vecs[i].dd, vecs[i].cnt);
      clockEdge();
    end

    // Fill/drain three times so pointers wrap around the storage.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < DEPTH; n++)
        cycle("wrap_fill", 1'b1, W'(32'h10 + r * DEPTH + n), 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < DEPTH; n++) begin
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        modelCheck("wrap_drain");
        checkValue("wrap_order", deq_data, W'(32'h10 + r * DEPTH + n));
        clockEdge();
      end
    end

    // Full with simultaneous enq/deq: only the dequeue fires.
    for (int n = 0; n < DEPTH; n++)
      cycle("full_fill", 1'b1, W'(32'h20 + n), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
    checkOutput("full_both", 1'b0, 1'b1, 32'h20, 3'd4);
    clockEdge();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_after", 1'b1, 1'b1, 32'h21, 3'd3);
    clockEdge();
    for (int n = 1; n < DEPTH; n++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkValue("full_drain", deq_data, W'(32'h20 + n));
      clockEdge();
    end
    cycle("full_empty", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Mid-occupancy simultaneous enq/deq keeps count steady.
    cycle("mid_fill", 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    cycle("mid_fill", 1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_both", 1'b1, 1'b1, 32'd7, 3'd2);
    clockEdge();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_deq8", 1'b1, 1'b1, 32'd8, 3'd2);
    clockEdge();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("mid_deq9", 1'b1, 1'b1, 32'd9, 3'd1);
    clockEdge();

    // Clear and reset at count 3, each with a concurrent enqueue.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 3; n++)
        cycle("flush_fill", 1'b1, W'(32'h40 + n), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h55, 1'b0, (k == 0), (k == 1));
      checkValue("flush_pre_count", W'(count), 32'd3);
      clockEdge();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput(k == 0 ? "after_clear" : "after_reset", 1'b1, 1'b0, 32'h0, 3'd0);
      clockEdge();
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      cycle("random", 1'($urandom), $urandom, 1'($urandom),
            ($urandom_range(31) == 0), ($urandom_range(127) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
